// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the bus note sequencer:
//   - state_e      : sequencer FSM states
//   - note fields  : tone / duration bit positions within a 32-bit note word
//   - TERMINATOR   : note word that ends a table pass
//   - SILENCE_WORD : value written to the tone register to mute the output
//   - tone_word()  : zero-extends the tone field of a note word for the bus
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_RWAIT     = 3'd2,
    S_WRITE     = 3'd3,
    S_WWAIT     = 3'd4,
    S_HOLD      = 3'd5,
    S_SIL_WRITE = 3'd6,
    S_SIL_WAIT  = 3'd7
  } state_e;

  localparam int TONE_MSB = 31;
  localparam int TONE_LSB = 16;
  localparam int DUR_MSB  = 15;
  localparam int DUR_LSB  = 0;

  localparam logic [31:0] TERMINATOR   = 32'h0000_0000;
  localparam logic [31:0] SILENCE_WORD = 32'h0000_0000;

  function automatic logic [31:0] tone_word(input logic [31:0] note);
    return {16'h0000, note[TONE_MSB:TONE_LSB]};
  endfunction

endpackage

// File: rtl/bus_note_sequencer_if.sv
// -----------------------------------------------------------------------------
// bus_note_sequencer_if
// FemtoRV32-style memory bus between an initiator (master) and a target
// (slave).
//   mem_addr  : byte address, valid while mem_rstrb or mem_wmask is active
//   mem_rstrb : one-cycle read strobe
//   mem_rdata : read data, valid in the first cycle after the strobe with
//               mem_rbusy low
//   mem_rbusy : read not yet complete
//   mem_wdata : write data, valid while mem_wmask is non-zero
//   mem_wmask : byte write enables, one cycle per write
//   mem_wbusy : write not yet complete
//
// Handshake: a transfer starts with a single-cycle strobe/mask. The target
// holds rbusy/wbusy high for as long as it needs; the transfer completes in
// the first following cycle in which the matching busy is low. The initiator
// issues nothing new until that completion.
// -----------------------------------------------------------------------------
interface bus_note_sequencer_if;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wbusy;

  modport master (
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    input  mem_rdata, mem_rbusy, mem_wbusy
  );

  modport slave (
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask,
    output mem_rdata, mem_rbusy, mem_wbusy
  );
endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
//   clk, reset : clock, asynchronous active-high reset
//   en_i       : count while high, hold while low
//   clr_i      : restart the count at 0 (wins over en_i)
//   tick_o     : high for one cycle at the end of each PRESCALE-cycle period
// With clr_i pulsed the cycle before en_i rises, the first tick comes exactly
// PRESCALE enabled cycles later.
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/bus_note_sequencer.sv
// -----------------------------------------------------------------------------
// bus_note_sequencer
// Autonomous bus initiator that plays a note table from memory: each 32-bit
// note word {tone[31:16], duration[15:0]} is fetched, the tone is written to
// the PWM tone register at TONE_ADDR, and the note is held for duration ticks
// of PRESCALE clk cycles. A zero word ends the table; the tone is then
// silenced and the pass either restarts (loop) or finishes with a done pulse.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle arm pulse, ignored while busy
//   stop           : one-cycle abort pulse
//   loop_en        : restart at base_addr at table end (sampled at start)
//   base_addr      : word-aligned table address (sampled at start)
//   bus            : memory bus, initiator side
//   busy           : sequencer owns the bus
//   done           : one-cycle pulse when a pass finishes or an abort ends
//   note_idx       : index of the current note in the table
//   dbg_state_o    : current FSM state
// -----------------------------------------------------------------------------
module bus_note_sequencer
  import seq_pkg::*;
#(
  parameter logic [31:0] TONE_ADDR = 32'h0043_0004,
  parameter int          PRESCALE  = 25000,
  parameter int          MAX_NOTES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop_en,
  input  logic [31:0]                 base_addr,
  bus_note_sequencer_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  note_idx,
  output state_e                      dbg_state_o
);

  localparam logic [8:0] MAX_N = 9'(MAX_NOTES);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] base_q, base_d;
  logic        loop_q, loop_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] dur_q, dur_d;
  logic [31:0] note_q, note_d;
  logic        abort_q, abort_d;
  logic        done_q, done_d;

  logic        abort_now;
  logic        hold_en;
  logic        pre_clr;
  logic        tick;

  logic [31:0] addr_c;
  logic        rstrb_c;
  logic [31:0] wdata_c;
  logic [3:0]  wmask_c;

  assign hold_en = (state_q == S_HOLD);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (hold_en),
    .clr_i  (pre_clr),
    .tick_o (tick)
  );

  // A stop arriving in the same cycle as a decision point must already
  // steer that decision, so decisions look at the flag and the pulse.
  assign abort_now = abort_q || stop;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    note_d  = note_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    pre_clr = 1'b0;
    addr_c  = 32'h0;
    rstrb_c = 1'b0;
    wdata_c = 32'h0;
    wmask_c = 4'h0;

    if (state_q != S_IDLE && stop) begin
      abort_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // stop beats start when both arrive together.
        if (start && !stop) begin
          base_d  = base_addr;
          ptr_d   = base_addr;
          loop_d  = loop_en;
          cnt_d   = 9'd0;
          abort_d = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        addr_c  = ptr_q;
        rstrb_c = 1'b1;
        state_d = S_RWAIT;
      end

      S_RWAIT: begin
        if (!bus.mem_rbusy) begin
          note_d = bus.mem_rdata;
          if (abort_now || bus.mem_rdata == TERMINATOR || cnt_q == MAX_N) begin
            state_d = S_SIL_WRITE;
          end else begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        addr_c  = TONE_ADDR;
        wdata_c = tone_word(note_q);
        wmask_c = 4'hF;
        state_d = S_WWAIT;
      end

      S_WWAIT: begin
        if (!bus.mem_wbusy) begin
          if (abort_now) begin
            state_d = S_SIL_WRITE;
          end else if (note_q[DUR_MSB:DUR_LSB] == 16'd0) begin
            ptr_d   = ptr_q + 32'd4;
            cnt_d   = (cnt_q == MAX_N) ? cnt_q : cnt_q + 9'd1;
            state_d = S_FETCH;
          end else begin
            dur_d   = note_q[DUR_MSB:DUR_LSB];
            pre_clr = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (stop) begin
          state_d = S_SIL_WRITE;
        end else if (tick) begin
          dur_d = dur_q - 16'd1;
          // The last tick of the note ends HOLD directly, so HOLD spans
          // exactly duration * PRESCALE cycles.
          if (dur_q == 16'd1) begin
            ptr_d   = ptr_q + 32'd4;
            cnt_d   = (cnt_q == MAX_N) ? cnt_q : cnt_q + 9'd1;
            state_d = S_FETCH;
          end
        end
      end

      S_SIL_WRITE: begin
        addr_c  = TONE_ADDR;
        wdata_c = SILENCE_WORD;
        wmask_c = 4'hF;
        state_d = S_SIL_WAIT;
      end

      S_SIL_WAIT: begin
        if (!bus.mem_wbusy) begin
          if (loop_q && !abort_now) begin
            ptr_d   = base_q;
            cnt_d   = 9'd0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            abort_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 32'h0;
      base_q  <= 32'h0;
      loop_q  <= 1'b0;
      cnt_q   <= 9'd0;
      dur_q   <= 16'd0;
      note_q  <= 32'h0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      loop_q  <= loop_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  // Bus outputs decode straight from the state register, so an asynchronous
  // reset drops every strobe in the same cycle.
  assign bus.mem_addr  = addr_c;
  assign bus.mem_rstrb = rstrb_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.mem_wmask = wmask_c;

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign note_idx    = (cnt_q > 9'd255) ? 8'hFF : cnt_q[7:0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_note_sequencer.sv
`timescale 1ns/1ps
module tb_bus_note_sequencer;
  import seq_pkg::*;

  localparam logic [31:0] TONE = 32'h0043_0004;
  localparam int          PS   = 4;
  localparam int          W    = 70;   // {kind[1:0], mask[3:0], addr[31:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, loop_en;
  logic [31:0] base_addr;
  logic        busy, done;
  logic [7:0]  note_idx;
  state_e      dbg_state;

  bus_note_sequencer_if bus ();

  bus_note_sequencer #(
    .TONE_ADDR (TONE),
    .PRESCALE  (PS),
    .MAX_NOTES (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .base_addr   (base_addr),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .note_idx    (note_idx),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           ev_cyc_q[$];
  logic [7:0]   ev_idx_q[$];
  int           n_ev;
  int           done_cnt;
  int           done_cyc;
  logic         busy_at_done;
  int           n_cmp = 0;
  int           n_bad = 0;

  logic [31:0] mem [logic [31:0]];
  int          rw = 0;
  int          ww = 0;
  int          rcnt = 0;
  int          wcnt = 0;
  logic [31:0] rd_pending;

  function automatic logic [W-1:0] rd_ev(input logic [31:0] a);
    return {2'd1, 4'h0, a, 32'h0};
  endfunction

  function automatic logic [W-1:0] wr_ev(input logic [31:0] d);
    return {2'd2, 4'hF, TONE, d};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // ---------------- bus target model + monitor ----------------
  // Responds on the falling edge so the DUT samples stable inputs.
  always @(negedge clk) begin
    logic [W-1:0] ev;
    logic [W-1:0] ex;
    logic         have_ev;
    have_ev = 1'b0;
    ev      = '0;
    if (reset) begin
      bus.mem_rbusy = 1'b0;
      bus.mem_wbusy = 1'b0;
      rcnt = 0;
      wcnt = 0;
    end else begin
      if (bus.mem_rstrb) begin
        have_ev    = 1'b1;
        ev         = {2'd1, bus.mem_wmask, bus.mem_addr, bus.mem_wdata};
        rd_pending = mem_rd(bus.mem_addr);
        if (rw > 0) begin
          bus.mem_rbusy = 1'b1;
          bus.mem_rdata = 32'hBAD0_0001;
          rcnt = rw + 1;
        end else begin
          bus.mem_rbusy = 1'b0;
          bus.mem_rdata = rd_pending;
          rcnt = 0;
        end
      end else if (rcnt > 0) begin
        rcnt = rcnt - 1;
        if (rcnt == 0) begin
          bus.mem_rbusy = 1'b0;
          bus.mem_rdata = rd_pending;
        end
      end

      if (bus.mem_wmask != 4'h0) begin
        have_ev = 1'b1;
        ev      = {2'd2, bus.mem_wmask, bus.mem_addr, bus.mem_wdata};
        if (ww > 0) begin
          bus.mem_wbusy = 1'b1;
          wcnt = ww + 1;
        end else begin
          bus.mem_wbusy = 1'b0;
          wcnt = 0;
        end
      end else if (wcnt > 0) begin
        wcnt = wcnt - 1;
        if (wcnt == 0) bus.mem_wbusy = 1'b0;
      end

      if (have_ev) begin
        n_ev = n_ev + 1;
        ev_cyc_q.push_back(cyc);
        ev_idx_q.push_back(note_idx);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bus_op_unexpected: got %h, expected none", ev);
        end else begin
          ex = exp_q.pop_front();
          if (ev !== ex) begin
            n_bad++;
            $display("FAIL bus_op: got %h, expected %h", ev, ex);
          end
        end
      end else if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bus_idle: addr %h wdata %h, expected 0", bus.mem_addr, bus.mem_wdata);
      end
    end

    if (done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    exp_q.delete();
    ev_cyc_q.delete();
    ev_idx_q.delete();
    n_ev     = 0;
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic lp, output int sc);
    @(negedge clk);
    #1;
    base_addr = base;
    loop_en   = lp;
    start     = 1'b1;
    sc        = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_events(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (n_ev >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; base_addr = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_rbusy = 1'b0; bus.mem_wbusy = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h, expected 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_rstrb !== 1'b0) begin n_bad++; $display("FAIL reset_rstrb: got %b, expected 0", bus.mem_rstrb); end
    n_cmp++; if (bus.mem_wmask !== 4'h0) begin n_bad++; $display("FAIL reset_wmask: got %h, expected 0", bus.mem_wmask); end
    n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h, expected 0", bus.mem_wdata); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b, expected 00", busy, done); end
    n_cmp++; if (note_idx !== 8'd0) begin n_bad++; $display("FAIL reset_idx: got %0d, expected 0", note_idx); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d, expected IDLE", dbg_state); end
    // start and stop together while idle: stays idle, no done
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || done_cnt !== 0) begin n_bad++; $display("FAIL start_stop_idle: busy %b done %0d, expected 0/0", busy, done_cnt); end
  endtask

  // Single note plus terminator; gaps are cycles between start, bus ops, done.
  task automatic run_single(input string nm, input int r_w, input int w_w);
    int sc;
    bit ok;
    int gaps[5];
    int prev;
    clear_log();
    rw = r_w; ww = w_w;
    mem.delete();
    mem[32'h100] = 32'h01F4_0003;
    mem[32'h104] = 32'h0;
    exp_q.push_back(rd_ev(32'h100));
    exp_q.push_back(wr_ev(32'h0000_01F4));
    exp_q.push_back(rd_ev(32'h104));
    exp_q.push_back(wr_ev(32'h0));
    gaps = '{1, 2 + r_w, 2 + w_w + 3 * PS, 2 + r_w, 2 + w_w};
    pulse_start(32'h100, 1'b0, sc);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_rise: got %b, expected 1", nm, busy); end
    wait_done(400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL %s_done_timeout: got no done, expected done", nm); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_done: got %b, expected 0", nm, busy_at_done); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL %s_missing_ops: got %0d left, expected 0", nm, exp_q.size()); end
    n_cmp++;
    if (ev_cyc_q.size() !== 4) begin
      n_bad++; $display("FAIL %s_op_count: got %0d, expected 4", nm, ev_cyc_q.size());
    end else begin
      prev = sc;
      for (int i = 0; i < 5; i++) begin
        int t;
        t = (i < 4) ? ev_cyc_q[i] : done_cyc;
        n_cmp++;
        if (t - prev !== gaps[i]) begin n_bad++; $display("FAIL %s_gap%0d: got %0d, expected %0d", nm, i, t - prev, gaps[i]); end
        prev = t;
      end
      n_cmp++; if (ev_idx_q[2] !== 8'd1) begin n_bad++; $display("FAIL %s_idx: got %0d, expected 1", nm, ev_idx_q[2]); end
    end
    repeat (5) step();
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d, expected 1", nm, done_cnt); end
  endtask

  task automatic test_basic();
    run_single("basic", 0, 0);
  endtask

  task automatic test_wait_states();
    run_single("wait", 3, 2);
  endtask

  task automatic test_loop();
    int sc;
    bit ok;
    int done_before;
    clear_log();
    rw = 0; ww = 0;
    mem.delete();
    mem[32'h100] = 32'h0100_0001;
    mem[32'h104] = 32'h0200_0002;
    mem[32'h108] = 32'h0;
    exp_q.push_back(rd_ev(32'h100));
    exp_q.push_back(wr_ev(32'h0000_0100));
    exp_q.push_back(rd_ev(32'h104));
    exp_q.push_back(wr_ev(32'h0000_0200));
    exp_q.push_back(rd_ev(32'h108));
    exp_q.push_back(wr_ev(32'h0));
    exp_q.push_back(rd_ev(32'h100));
    exp_q.push_back(wr_ev(32'h0));   // silence after the abort below
    pulse_start(32'h100, 1'b1, sc);
    wait_events(7, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL loop_refetch_timeout: got %0d ops, expected 7", n_ev); end
    done_before = done_cnt;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (done_before !== 0) begin n_bad++; $display("FAIL loop_no_done: got %0d, expected 0", done_before); end
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL loop_done_timeout: got no done, expected done"); end
    n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL loop_missing_ops: got %0d left, expected 0", exp_q.size()); end
    n_cmp++;
    if (ev_cyc_q.size() !== 8) begin
      n_bad++; $display("FAIL loop_op_count: got %0d, expected 8", ev_cyc_q.size());
    end else begin
      n_cmp++; if (ev_idx_q[6] !== 8'd0) begin n_bad++; $display("FAIL loop_idx: got %0d, expected 0", ev_idx_q[6]); end
      n_cmp++; if (ev_idx_q[4] !== 8'd2) begin n_bad++; $display("FAIL loop_term_idx: got %0d, expected 2", ev_idx_q[4]); end
      n_cmp++; if (ev_cyc_q[6] - ev_cyc_q[5] !== 2) begin n_bad++; $display("FAIL loop_regap: got %0d, expected 2", ev_cyc_q[6] - ev_cyc_q[5]); end
    end
    repeat (5) step();
  endtask

  task automatic test_stop_hold();
    int sc;
    bit ok;
    int stop_cyc;
    clear_log();
    rw = 0; ww = 0;
    mem.delete();
    mem[32'h200] = 32'h0300_0005;
    mem[32'h204] = 32'h0400_0005;
    mem[32'h208] = 32'h0;
    exp_q.push_back(rd_ev(32'h200));
    exp_q.push_back(wr_ev(32'h0000_0300));
    exp_q.push_back(rd_ev(32'h204));
    exp_q.push_back(wr_ev(32'h0000_0400));
    exp_q.push_back(wr_ev(32'h0));
    pulse_start(32'h200, 1'b0, sc);
    wait_events(4, 300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stop_note1_timeout: got %0d ops, expected 4", n_ev); end
    repeat (5) step();
    n_cmp++; if (dbg_state !== S_HOLD) begin n_bad++; $display("FAIL stop_in_hold: got %0d, expected HOLD", dbg_state); end
    stop     = 1'b1;
    stop_cyc = cyc;
    step();
    stop = 1'b0;
    wait_done(100, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stop_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (ev_cyc_q.size() !== 5) begin
      n_bad++; $display("FAIL stop_op_count: got %0d, expected 5", ev_cyc_q.size());
    end else begin
      n_cmp++;
      if (ev_cyc_q[4] - stop_cyc < 1 || ev_cyc_q[4] - stop_cyc > 3) begin
        n_bad++; $display("FAIL stop_silence_delay: got %0d, expected 1..3", ev_cyc_q[4] - stop_cyc);
      end
      n_cmp++; if (done_cyc - ev_cyc_q[4] !== 2) begin n_bad++; $display("FAIL stop_done_gap: got %0d, expected 2", done_cyc - ev_cyc_q[4]); end
    end
    repeat (20) step();
    n_cmp++; if (n_ev !== 5) begin n_bad++; $display("FAIL stop_no_refetch: got %0d ops, expected 5", n_ev); end
    n_cmp++; if (dbg_state !== S_IDLE || busy !== 1'b0) begin n_bad++; $display("FAIL stop_idle: state %0d busy %b, expected IDLE/0", dbg_state, busy); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stop_done_count: got %0d, expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int sc;
    bit ok;
    int gaps[7];
    int prev;
    clear_log();
    rw = 0; ww = 0;
    mem.delete();
    mem[32'h300] = 32'h0050_0000;
    mem[32'h304] = 32'h0064_0001;
    mem[32'h308] = 32'h0;
    mem[32'h200] = 32'h0777_0001;
    exp_q.push_back(rd_ev(32'h300));
    exp_q.push_back(wr_ev(32'h0000_0050));
    exp_q.push_back(rd_ev(32'h304));
    exp_q.push_back(wr_ev(32'h0000_0064));
    exp_q.push_back(rd_ev(32'h308));
    exp_q.push_back(wr_ev(32'h0));
    gaps = '{1, 2, 2, 2, 2 + PS, 2, 2};
    pulse_start(32'h300, 1'b0, sc);
    wait_events(2, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_first_write_timeout: got %0d ops, expected 2", n_ev); end
    base_addr = 32'h200;   // a re-arm while busy must be ignored
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_done_timeout: got no done, expected done"); end
    n_cmp++;
    if (ev_cyc_q.size() !== 6) begin
      n_bad++; $display("FAIL b2b_op_count: got %0d, expected 6", ev_cyc_q.size());
    end else begin
      prev = sc;
      for (int i = 0; i < 7; i++) begin
        int t;
        t = (i < 6) ? ev_cyc_q[i] : done_cyc;
        n_cmp++;
        if (t - prev !== gaps[i]) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d, expected %0d", i, t - prev, gaps[i]); end
        prev = t;
      end
    end
    repeat (10) step();
    n_cmp++; if (done_cnt !== 1 || n_ev !== 6) begin n_bad++; $display("FAIL b2b_after: done %0d ops %0d, expected 1/6", done_cnt, n_ev); end
  endtask

  task automatic test_reset_mid();
    int sc;
    bit ok;
    clear_log();
    rw = 0; ww = 5;
    mem.delete();
    mem[32'h400] = 32'h0070_0002;
    mem[32'h404] = 32'h0;
    exp_q.push_back(rd_ev(32'h400));
    exp_q.push_back(wr_ev(32'h0000_0070));
    pulse_start(32'h400, 1'b0, sc);
    wait_events(2, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_write_timeout: got %0d ops, expected 2", n_ev); end
    step();
    n_cmp++; if (dbg_state !== S_WWAIT) begin n_bad++; $display("FAIL rst_in_wwait: got %0d, expected WWAIT", dbg_state); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_addr !== 32'h0 || bus.mem_rstrb !== 1'b0 || bus.mem_wmask !== 4'h0 ||
        bus.mem_wdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_async_outputs: addr %h rstrb %b wmask %h wdata %h busy %b done %b idx %0d, expected all 0",
               bus.mem_addr, bus.mem_rstrb, bus.mem_wmask, bus.mem_wdata, busy, done, note_idx);
    end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL rst_async_state: got %0d, expected IDLE", dbg_state); end
    repeat (2) step();
    reset = 1'b0;
    ww = 0;
    repeat (20) step();
    n_cmp++; if (n_ev !== 2) begin n_bad++; $display("FAIL rst_no_silence: got %0d ops, expected 2", n_ev); end
    n_cmp++; if (dbg_state !== S_IDLE || busy !== 1'b0 || done_cnt !== 0) begin n_bad++; $display("FAIL rst_idle_after: state %0d busy %b done %0d, expected IDLE/0/0", dbg_state, busy, done_cnt); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_wait_states();
    test_loop();
    test_stop_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
